seq_det_ctr: RTL and testbench

//  Parametrised serial sequence detector and counter; successor to the fixed-pattern seq_ctr.
//  - Compares a 1-bit serial input against a runtime-programmable PAT_W-bit pattern.
//  - Emits a one-cycle match pulse and keeps a saturating match count.
//  - Runtime mode: overlapping or non-overlapping detection.
//  - Sits between a serial front end and status/interrupt logic.

---
 rtl/seq_det_ctr.sv | 97 +++++++++
 tb/tb_seq_det_ctr.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctr.sv
// Serial sequence detector with a runtime-programmable pattern, overlapping or
// non-overlapping detection, a registered match pulse and a saturating match counter.
module seq_det_ctr #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ip,
    input  logic [PAT_W-1:0] pat,
    input  logic             overlap,
    input  logic             clr,
    output logic             opt,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam int              FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_MAX - {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PAT_W-2:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic              opt_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              sat_r;

    logic [PAT_W-1:0]  win_s;
    logic              full_s;
    logic              hit_s;
    logic [FILL_W-1:0] fill_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              sat_nxt_s;

    // Match detection and next-state values for an accepted sample
    always_comb begin
        win_s      = {hist_r, ip};
        full_s     = (fill_r == FILL_MAX);
        hit_s      = en & full_s & (win_s == pat);
        fill_nxt_s = fill_r;
        cnt_nxt_s  = cnt_r;
        sat_nxt_s  = sat_r;

        // Non-overlapping mode consumes the matched bits, so history must refill.
        if (hit_s && !overlap) begin
            fill_nxt_s = {FILL_W{1'b0}};
        end else if (full_s) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
        end

        if (hit_s && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end

        if (hit_s && (cnt_r == CNT_PRE)) begin
            sat_nxt_s = 1'b1;
        end else begin
            sat_nxt_s = sat_r;
        end
    end

    // State and registered outputs; clear beats sample enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= {(PAT_W-1){1'b0}};
            fill_r <= {FILL_W{1'b0}};
            opt_r  <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            sat_r  <= 1'b0;
        end else if (clr) begin
            hist_r <= {(PAT_W-1){1'b0}};
            fill_r <= {FILL_W{1'b0}};
            opt_r  <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            sat_r  <= 1'b0;
        end else if (en) begin
            hist_r <= win_s[PAT_W-2:0];
            fill_r <= fill_nxt_s;
            opt_r  <= hit_s;
            cnt_r  <= cnt_nxt_s;
            sat_r  <= sat_nxt_s;
        end else begin
            opt_r  <= 1'b0;
        end
    end

    assign opt = opt_r;
    assign cnt = cnt_r;
    assign sat = sat_r;

endmodule

// File: tb/tb_seq_det_ctr.sv
// Directed bench for seq_det_ctr: a default instance (PAT_W=4, CNT_W=8) and a
// CNT_W=2 instance sharing the same stimulus for the saturation case.
module tb_seq_det_ctr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       ip = 1'b0;
    logic [3:0] pat = 4'b1011;
    logic       overlap = 1'b1;
    logic       clr = 1'b0;

    logic       opt_a;
    logic [7:0] cnt_a;
    logic       sat_a;
    logic       opt_b;
    logic [1:0] cnt_b;
    logic       sat_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_det_ctr #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .ip(ip), .pat(pat),
        .overlap(overlap), .clr(clr), .opt(opt_a), .cnt(cnt_a), .sat(sat_a)
    );

    seq_det_ctr #(.PAT_W(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .en(en), .ip(ip), .pat(pat),
        .overlap(overlap), .clr(clr), .opt(opt_b), .cnt(cnt_b), .sat(sat_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one bit, let the next rising edge sample it, then settle
    task automatic step(input logic b);
        ip = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [6:0] bits;
    logic [6:0] exp_opt;
    logic [6:0] exp_sat;
    logic [1:0] exp_cnt [7];

    initial begin
        // Reset state
        rst = 1'b1;
        #2;
        check("rst_opt", opt_a, 32'd0);
        check("rst_cnt", cnt_a, 32'd0);
        check("rst_sat", sat_a, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: overlapping, 1011011
        overlap = 1'b1; pat = 4'b1011;
        bits = 7'b1011011; exp_opt = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            step(bits[i]);
            check($sformatf("t1_opt%0d", 6 - i), opt_a, exp_opt[i]);
        end
        check("t1_cnt", cnt_a, 32'd2);

        // 2: non-overlapping, same stream
        do_reset();
        overlap = 1'b0;
        exp_opt = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            step(bits[i]);
            check($sformatf("t2_opt%0d", 6 - i), opt_a, exp_opt[i]);
        end
        check("t2_cnt", cnt_a, 32'd1);

        // 3: all-zero pattern must not fire on the reset-zeroed history
        do_reset();
        overlap = 1'b1; pat = 4'b0000;
        exp_opt = 7'b0001110;
        for (int i = 6; i >= 1; i--) begin
            step(1'b0);
            check($sformatf("t3_opt%0d", 6 - i), opt_a, exp_opt[i]);
        end
        check("t3_cnt", cnt_a, 32'd3);

        // 4: saturation on the 2-bit counter instance
        do_reset();
        pat = 4'b1111;
        exp_opt = 7'b0001111;
        exp_sat = 7'b0000011;
        exp_cnt = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        for (int i = 6; i >= 0; i--) begin
            step(1'b1);
            check($sformatf("t4_opt%0d", 6 - i), opt_b, exp_opt[i]);
            check($sformatf("t4_cnt%0d", 6 - i), cnt_b, exp_cnt[6 - i]);
            check($sformatf("t4_sat%0d", 6 - i), sat_b, exp_sat[i]);
        end
        clr = 1'b1;
        step(1'b1);
        clr = 1'b0;
        check("t4_clr_opt", opt_b, 32'd0);
        check("t4_clr_cnt", cnt_b, 32'd0);
        check("t4_clr_sat", sat_b, 32'd0);

        // 5: en=0 holds history and suppresses pulses
        do_reset();
        pat = 4'b1011;
        step(1'b1); step(1'b0); step(1'b1);
        en = 1'b0;
        step(1'b1); check("t5_hold0", opt_a, 32'd0);
        step(1'b0); check("t5_hold1", opt_a, 32'd0);
        step(1'b1); check("t5_hold2", opt_a, 32'd0);
        en = 1'b1;
        step(1'b1); check("t5_hit", opt_a, 32'd1);
        step(1'b0); check("t5_after", opt_a, 32'd0);
        check("t5_cnt", cnt_a, 32'd1);

        // 6: asynchronous reset mid-cycle
        do_reset();
        step(1'b1); step(1'b0); step(1'b1); step(1'b1);
        check("t6_pre_opt", opt_a, 32'd1);
        check("t6_pre_cnt", cnt_a, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_opt", opt_a, 32'd0);
        check("t6_async_cnt", cnt_a, 32'd0);
        check("t6_async_sat", sat_a, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1); step(1'b0); step(1'b1);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1); check("t6_fresh0", opt_a, 32'd0);
        step(1'b0); check("t6_fresh1", opt_a, 32'd0);
        step(1'b1); check("t6_fresh2", opt_a, 32'd0);
        step(1'b1); check("t6_fresh3", opt_a, 32'd1);
        check("t6_cnt", cnt_a, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
